// File: rtl/issue_scoreboard.sv
// issue_scoreboard: register-write tracking and issue gating between decode
// and execute. Holds one busy bit per architectural register, an outstanding
// write count and a saturating stall counter. A sticky wb_err flags a
// write-back to a register that had no pending write.
// Build option: define SCB_WB_BYPASS_EN so a same-cycle write-back clears the
// hazard for a waiting consumer; undefined, hazards use the registered busy
// bits only.
module issue_scoreboard #(
  parameter int MAX_PENDING = 4,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic              rs1_r_ena,
  input  logic [4:0]        rs1_r_addr,
  input  logic              rs2_r_ena,
  input  logic [4:0]        rs2_r_addr,
  input  logic              rd_w_ena,
  input  logic [4:0]        rd_w_addr,
  output logic              ex_valid,
  input  logic              ex_ready,
  input  logic              wb_valid,
  input  logic [4:0]        wb_addr,
  input  logic              flush,
  output logic [31:0]       busy_vec,
  output logic [4:0]        pend_cnt,
  output logic [PERF_W-1:0] stall_cnt,
  output logic              wb_err
);

  localparam logic [4:0] MAX_P = 5'(MAX_PENDING);

  logic [31:0]       busy_q, busy_d;
  logic [4:0]        pend_q, pend_d;
  logic [PERF_W-1:0] stall_q, stall_d;
  logic              wb_err_q, wb_err_d;

  logic [31:0] busy_haz;
  logic        hazard;
  logic        cap_ok;
  logic        gate;
  logic        issue;
  logic        set_en;
  logic        clr_en;
  logic        wb_bad;

  // Hazard and capacity checks; rst low blocks issue without waiting for an edge.
  always_comb begin
    busy_haz = busy_q;
`ifdef SCB_WB_BYPASS_EN
    if (wb_valid) busy_haz[wb_addr] = 1'b0;
`endif
    busy_haz[0] = 1'b0;
    hazard = (rs1_r_ena & busy_haz[rs1_r_addr])
           | (rs2_r_ena & busy_haz[rs2_r_addr])
           | (rd_w_ena  & busy_haz[rd_w_addr]);
    cap_ok   = ~rd_w_ena | (rd_w_addr == 5'd0) | (pend_q < MAX_P);
    gate     = rst & ~hazard & cap_ok & ~flush;
    ex_valid = id_valid & gate;
    id_ready = ex_ready & gate;
    issue    = ex_valid & ex_ready;
    set_en   = issue & rd_w_ena & (rd_w_addr != 5'd0);
    clr_en   = wb_valid & (wb_addr != 5'd0) & busy_q[wb_addr];
    wb_bad   = wb_valid & (wb_addr != 5'd0) & ~busy_q[wb_addr];
  end

  // Next-state for busy bits, pending count, stall counter and error flag.
  always_comb begin
    busy_d   = busy_q;
    pend_d   = pend_q;
    stall_d  = stall_q;
    wb_err_d = wb_err_q;

    if (flush) begin
      // Flush wins over any same-cycle issue or write-back.
      busy_d = '0;
      pend_d = '0;
    end else begin
      if (clr_en) busy_d[wb_addr]   = 1'b0;
      // Set after clear so a same-register collision leaves the bit busy.
      if (set_en) busy_d[rd_w_addr] = 1'b1;
      case ({set_en, clr_en})
        2'b10:   pend_d = pend_q + 5'd1;
        2'b01:   pend_d = pend_q - 5'd1;
        default: pend_d = pend_q;
      endcase
      if (wb_bad) wb_err_d = 1'b1;
    end
    busy_d[0] = 1'b0;

    if (id_valid && !id_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= '0;
      pend_q   <= '0;
      stall_q  <= '0;
      wb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      pend_q   <= pend_d;
      stall_q  <= stall_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign busy_vec  = busy_q;
  assign pend_cnt  = pend_q;
  assign stall_cnt = stall_q;
  assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard. Expected values are queued when the
// stimulus is driven and popped/compared once the DUT has produced them.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_ready;
  logic        rs1_r_ena, rs2_r_ena, rd_w_ena;
  logic [4:0]  rs1_r_addr, rs2_r_addr, rd_w_addr;
  logic        ex_valid, ex_ready;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic        flush;
  logic [31:0] busy_vec;
  logic [4:0]  pend_cnt;
  logic [3:0]  stall_cnt;
  logic        wb_err;

  always #5 clk = ~clk;

  issue_scoreboard #(.MAX_PENDING(4), .PERF_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .rs1_r_ena(rs1_r_ena), .rs1_r_addr(rs1_r_addr),
    .rs2_r_ena(rs2_r_ena), .rs2_r_addr(rs2_r_addr),
    .rd_w_ena(rd_w_ena), .rd_w_addr(rd_w_addr),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .flush(flush),
    .busy_vec(busy_vec), .pend_cnt(pend_cnt),
    .stall_cnt(stall_cnt), .wb_err(wb_err)
  );

  typedef struct {
    string       name;
    string       sig;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_run  = 0;
  int   n_fail = 0;
  logic [3:0] exp_stall;

  function automatic logic [31:0] obs(string sig);
    if (sig == "busy")     return busy_vec;
    if (sig == "pend")     return {27'd0, pend_cnt};
    if (sig == "stall")    return {28'd0, stall_cnt};
    if (sig == "wb_err")   return {31'd0, wb_err};
    if (sig == "ex_valid") return {31'd0, ex_valid};
    if (sig == "id_ready") return {31'd0, id_ready};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic expect_v(input string name, input string sig, input logic [31:0] e);
    exp_t x;
    x.name = name;
    x.sig  = sig;
    x.exp  = e;
    q.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    logic [31:0] o;
    while (q.size() > 0) begin
      x = q.pop_front();
      o = obs(x.sig);
      n_run++;
      assert (o === x.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", x.name, o, x.exp);
      end
    end
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic clr_in();
    id_valid   = 1'b0;
    rs1_r_ena  = 1'b0; rs1_r_addr = 5'd0;
    rs2_r_ena  = 1'b0; rs2_r_addr = 5'd0;
    rd_w_ena   = 1'b0; rd_w_addr  = 5'd0;
    ex_ready   = 1'b1;
    wb_valid   = 1'b0; wb_addr    = 5'd0;
    flush      = 1'b0;
  endtask

  task automatic inst(input logic re1, input logic [4:0] a1,
                      input logic re2, input logic [4:0] a2,
                      input logic we,  input logic [4:0] rd);
    id_valid   = 1'b1;
    rs1_r_ena  = re1; rs1_r_addr = a1;
    rs2_r_ena  = re2; rs2_r_addr = a2;
    rd_w_ena   = we;  rd_w_addr  = rd;
  endtask

  initial begin
    rst = 1'b0;
    clr_in();
    inst(0, 5'd0, 0, 5'd0, 1, 5'd5);
    exp_stall = 4'd0;

    // Reset holds everything low, even with a would-be issue presented.
    #3;
    expect_v("rst_busy", "busy", 32'h0);
    expect_v("rst_pend", "pend", 32'h0);
    expect_v("rst_stall", "stall", 32'h0);
    expect_v("rst_wb_err", "wb_err", 32'h0);
    expect_v("rst_ex_valid", "ex_valid", 32'h0);
    expect_v("rst_id_ready", "id_ready", 32'h0);
    settle();
    expect_v("rst_edge_busy", "busy", 32'h0);
    tick();
    rst = 1'b1;

    // Issue rd=5.
    expect_v("a_ex_valid", "ex_valid", 32'h1);
    expect_v("a_id_ready", "id_ready", 32'h1);
    settle();
    expect_v("a_busy", "busy", 32'h20);
    expect_v("a_pend", "pend", 32'h1);
    expect_v("a_stall", "stall", 32'h0);
    tick();

    // Consumer of x5 stalls and counts stall cycles.
    inst(1, 5'd5, 0, 5'd0, 0, 5'd0);
    expect_v("b_id_ready", "id_ready", 32'h0);
    expect_v("b_ex_valid", "ex_valid", 32'h0);
    settle();
    exp_stall++;
    expect_v("b_stall1", "stall", {28'd0, exp_stall});
    tick();
    exp_stall++;
    expect_v("b_stall2", "stall", {28'd0, exp_stall});
    expect_v("b_busy", "busy", 32'h20);
    tick();

    // Write-back of x5 while the consumer waits.
    wb_valid = 1'b1; wb_addr = 5'd5;
`ifdef SCB_WB_BYPASS_EN
    expect_v("c_ex_valid_wb", "ex_valid", 32'h1);
    settle();
    expect_v("c_busy", "busy", 32'h0);
    expect_v("c_pend", "pend", 32'h0);
    expect_v("c_stall", "stall", {28'd0, exp_stall});
    tick();
`else
    expect_v("c_ex_valid_wb", "ex_valid", 32'h0);
    settle();
    exp_stall++;
    expect_v("c_busy", "busy", 32'h0);
    expect_v("c_pend", "pend", 32'h0);
    expect_v("c_stall", "stall", {28'd0, exp_stall});
    tick();
    wb_valid = 1'b0;
    expect_v("c_ex_valid_after", "ex_valid", 32'h1);
    settle();
    expect_v("c_stall_after", "stall", {28'd0, exp_stall});
    tick();
`endif

    // Decode inputs without id_valid must not touch tracking state.
    clr_in();
    rd_w_ena = 1'b1; rd_w_addr = 5'd12;
    expect_v("idle_ex_valid", "ex_valid", 32'h0);
    settle();
    expect_v("idle_busy", "busy", 32'h0);
    expect_v("idle_pend", "pend", 32'h0);
    expect_v("idle_stall", "stall", {28'd0, exp_stall});
    tick();

    // Fill to capacity with x1..x4.
    for (int i = 1; i <= 4; i++) begin
      inst(0, 5'd0, 0, 5'd0, 1, 5'(i));
      expect_v($sformatf("d_pend%0d", i), "pend", 32'(i));
      tick();
    end
    expect_v("d_busy_full", "busy", 32'h1E);
    settle();

    inst(0, 5'd0, 0, 5'd0, 1, 5'd6);
    expect_v("d_cap_id_ready", "id_ready", 32'h0);
    expect_v("d_cap_ex_valid", "ex_valid", 32'h0);
    settle();
    exp_stall++;
    expect_v("d_cap_stall", "stall", {28'd0, exp_stall});
    expect_v("d_cap_pend", "pend", 32'h4);
    tick();

    inst(1, 5'd8, 0, 5'd0, 0, 5'd0);
    expect_v("d_nowr_ex_valid", "ex_valid", 32'h1);
    settle();
    expect_v("d_nowr_pend", "pend", 32'h4);
    expect_v("d_nowr_busy", "busy", 32'h1E);
    tick();

    inst(0, 5'd0, 0, 5'd0, 1, 5'd0);
    expect_v("d_x0_ex_valid", "ex_valid", 32'h1);
    settle();
    expect_v("d_x0_busy", "busy", 32'h1E);
    expect_v("d_x0_pend", "pend", 32'h4);
    tick();

    // Retire x1, x2; then issue x7.
    clr_in();
    wb_valid = 1'b1; wb_addr = 5'd1;
    expect_v("e_wb1_busy", "busy", 32'h1C);
    expect_v("e_wb1_pend", "pend", 32'h3);
    tick();
    wb_addr = 5'd2;
    expect_v("e_wb2_busy", "busy", 32'h18);
    expect_v("e_wb2_pend", "pend", 32'h2);
    tick();
    wb_valid = 1'b0;
    inst(0, 5'd0, 0, 5'd0, 1, 5'd7);
    expect_v("e_x7_busy", "busy", 32'h98);
    expect_v("e_x7_pend", "pend", 32'h3);
    tick();

    // Issue x10 and retire x4 in the same cycle.
    inst(0, 5'd0, 0, 5'd0, 1, 5'd10);
    wb_valid = 1'b1; wb_addr = 5'd4;
    expect_v("e_mix_ex_valid", "ex_valid", 32'h1);
    settle();
    expect_v("e_mix_busy", "busy", 32'h488);
    expect_v("e_mix_pend", "pend", 32'h3);
    tick();

    // Second write to a busy register waits.
    wb_valid = 1'b0;
    inst(0, 5'd0, 0, 5'd0, 1, 5'd7);
    expect_v("e_waw_id_ready", "id_ready", 32'h0);
    settle();
    exp_stall++;
    expect_v("e_waw_stall", "stall", {28'd0, exp_stall});
    tick();

`ifdef SCB_WB_BYPASS_EN
    // Same-register issue and write-back: stays busy, count unchanged.
    wb_valid = 1'b1; wb_addr = 5'd7;
    expect_v("e_same_ex_valid", "ex_valid", 32'h1);
    settle();
    expect_v("e_same_busy", "busy", 32'h488);
    expect_v("e_same_pend", "pend", 32'h3);
    tick();
`endif

    // Write-back to a non-busy register raises sticky wb_err.
    clr_in();
    wb_valid = 1'b1; wb_addr = 5'd9;
    expect_v("f_err_busy", "busy", 32'h488);
    expect_v("f_err_pend", "pend", 32'h3);
    expect_v("f_err_set", "wb_err", 32'h1);
    tick();
    wb_valid = 1'b0;
    expect_v("f_err_hold", "wb_err", 32'h1);
    tick();

    // Flush overrides a same-cycle issue and write-back.
    inst(0, 5'd0, 0, 5'd0, 1, 5'd11);
    wb_valid = 1'b1; wb_addr = 5'd3;
    flush = 1'b1;
    expect_v("f_fl_ex_valid", "ex_valid", 32'h0);
    expect_v("f_fl_id_ready", "id_ready", 32'h0);
    settle();
    exp_stall++;
    expect_v("f_fl_busy", "busy", 32'h0);
    expect_v("f_fl_pend", "pend", 32'h0);
    expect_v("f_fl_wb_err", "wb_err", 32'h1);
    expect_v("f_fl_stall", "stall", {28'd0, exp_stall});
    tick();
    clr_in();

    // Build up three outstanding writes, then reset mid-cycle.
    for (int i = 1; i <= 3; i++) begin
      inst(0, 5'd0, 0, 5'd0, 1, 5'(i));
      tick();
    end
    expect_v("g_pre_pend", "pend", 32'h3);
    settle();
    inst(0, 5'd0, 0, 5'd0, 1, 5'd4);
    #2;
    rst = 1'b0;
    #1;
    expect_v("g_rst_busy", "busy", 32'h0);
    expect_v("g_rst_pend", "pend", 32'h0);
    expect_v("g_rst_stall", "stall", 32'h0);
    expect_v("g_rst_wb_err", "wb_err", 32'h0);
    expect_v("g_rst_ex_valid", "ex_valid", 32'h0);
    expect_v("g_rst_id_ready", "id_ready", 32'h0);
    drain();
    tick();
    rst = 1'b1;
    exp_stall = 4'd0;

    inst(0, 5'd0, 0, 5'd0, 1, 5'd1);
    expect_v("g_post_ex_valid", "ex_valid", 32'h1);
    settle();
    expect_v("g_post_busy", "busy", 32'h2);
    expect_v("g_post_pend", "pend", 32'h1);
    tick();
    inst(0, 5'd0, 0, 5'd0, 1, 5'd0);
    expect_v("g_rd0_busy", "busy", 32'h2);
    expect_v("g_rd0_pend", "pend", 32'h1);
    tick();

    // Stall counter saturates at all-ones.
    inst(1, 5'd1, 0, 5'd0, 0, 5'd0);
    for (int i = 0; i < 17; i++) tick();
    expect_v("h_stall_sat", "stall", 32'hF);
    settle();

    clr_in();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
